// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared widths, memory depth and loader state encoding
package instr_loader_pkg;

   localparam int WORD     = 32;
   localparam int BYTE     = 8;
   localparam int INS_SIZE = 256;
   localparam int LANES    = WORD / BYTE;

   typedef logic [1:0] ld_state_t;

   localparam logic [1:0] LD_IDLE = 2'd0;
   localparam logic [1:0] LD_LOAD = 2'd1;
   localparam logic [1:0] LD_DONE = 2'd2;
   localparam logic [1:0] LD_ERR  = 2'd3;

   // bit offset of byte lane idx inside a big-endian word (lane 0 is the MSB)
   function automatic int lane_shift(input logic [1:0] idx);
      return BYTE * (LANES - 1 - int'(idx));
   endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// byte_packer: big-endian byte-to-word packing with zero-filled tail and word-complete flag
module byte_packer
   import instr_loader_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear_i,
   input  logic            en_i,
   input  logic            last_i,
   input  logic [BYTE-1:0] byte_i,
   output logic [WORD-1:0] word_o,
   output logic            complete_o
);

   logic [1:0]      idx_q, idx_d;
   logic [WORD-1:0] pack_q, pack_d;

   assign word_o     = pack_q | (WORD'(byte_i) << lane_shift(idx_q));
   assign complete_o = idx_q == 2'd3 || last_i;

   // a finished word empties the register so the next word starts zero-filled
   always_comb begin
      idx_d  = clear_i ? 2'd0 : en_i ? (complete_o ? 2'd0 : idx_q + 2'd1) : idx_q;
      pack_d = clear_i ? '0 : en_i ? (complete_o ? '0 : word_o) : pack_q;
   end

   // lane index and partial word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= 2'd0;
         pack_q <= '0;
      end else begin
         idx_q  <= idx_d;
         pack_q <= pack_d;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: byte-stream loader writing packed words into instruction memory (INSTR_LOADER_CHECKSUM_EN adds an XOR checksum)
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int INS_SIZE = instr_loader_pkg::INS_SIZE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [BYTE-1:0] byte_in,
   input  logic            byte_valid,
   input  logic            byte_last,
   output logic            byte_ready,
   output logic            wr_en,
   output logic [WORD-1:0] wr_addr,
   output logic [WORD-1:0] wr_data,
   output logic [WORD-1:0] word_count,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [WORD-1:0] checksum
);

   ld_state_t       state_q, state_d;
   logic            wr_en_q;
   logic [WORD-1:0] wr_addr_q, wr_data_q, word_count_q, word_count_d;
   logic            clear, xfer, full, wr_fire, complete;
   logic [WORD-1:0] word;

   assign byte_ready = state_q == LD_LOAD;
   assign busy       = byte_ready;
   assign done       = state_q == LD_DONE;
   assign error      = state_q == LD_ERR;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign word_count = word_count_q;

   assign clear   = start && state_q != LD_LOAD;
   assign xfer    = byte_valid && byte_ready;
   assign full    = word_count_q == WORD'(INS_SIZE);
   assign wr_fire = xfer && !full && complete;

   byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (clear),
      .en_i      (xfer && !full),
      .last_i    (byte_last),
      .byte_i    (byte_in),
      .word_o    (word),
      .complete_o(complete)
   );

   // overflow outranks byte_last; start restarts from any state but LOAD
   always_comb begin
      state_d      = clear ? LD_LOAD : xfer && full ? LD_ERR : xfer && byte_last ? LD_DONE : state_q;
      word_count_d = clear ? '0 : wr_fire ? word_count_q + 1'b1 : word_count_q;
   end

   // state, write port and word counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LD_IDLE;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_en_q      <= wr_fire;
         word_count_q <= word_count_d;
         if (wr_fire) begin
            wr_addr_q <= word_count_q;
            wr_data_q <= word;
         end
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [WORD-1:0] checksum_q;

   // running XOR of every word written in this load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) checksum_q <= '0;
      else if (clear) checksum_q <= '0;
      else if (wr_fire) checksum_q <= checksum_q ^ word;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized and directed checks of instr_loader against a queue-based reference model
module tb_instr_loader;

   localparam int DEPTH = 4;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0, byte_last = 1'b0;
   logic        byte_ready, wr_en, busy, done, error;
   logic [31:0] wr_addr, wr_data, word_count, checksum;

   int checks = 0, failures = 0, cyc = 0;
   logic [31:0] exp_data[$];
   int          exp_addr[$];
   int          wr_cyc[$];

   instr_loader #(.INS_SIZE(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .word_count(word_count),
      .busy(busy), .done(done), .error(error), .checksum(checksum)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // scoreboard: every write must match the next expected word
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         checks++;
         wr_cyc.push_back(cyc);
         if (exp_data.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
         end else begin
            logic [31:0] ed;
            int ea;
            ed = exp_data.pop_front();
            ea = exp_addr.pop_front();
            if (wr_data !== ed || wr_addr !== 32'(ea)) begin
               failures++;
               $display("FAIL write got=%h@%0d exp=%h@%0d", wr_data, wr_addr, ed, ea);
            end
         end
      end
   end

   // reference: byte i lands in word i/4 at lane i%4; words beyond DEPTH overflow
   function automatic void model(input logic [7:0] b[$], input bit last, output bit err,
                                 output int nw, output logic [31:0] cks);
      int n;
      n   = b.size();
      err = n > 4 * DEPTH;
      nw  = err ? DEPTH : last ? (n + 3) / 4 : n / 4;
      cks = 32'h0;
      for (int k = 0; k < nw; k++) begin
         logic [31:0] w;
         w = 32'h0;
         for (int j = 0; j < 4; j++)
            if (4 * k + j < n) w[31 - 8 * j -: 8] = b[4 * k + j];
         exp_data.push_back(w);
         exp_addr.push_back(k);
         cks ^= w;
      end
`ifndef INSTR_LOADER_CHECKSUM_EN
      cks = 32'h0;
`endif
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic begin_load();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // gap<0 picks random idle cycles; start is pulsed in the gap before byte start_at
   task automatic drive(input logic [7:0] b[$], input bit last, input int gap, input int start_at);
      for (int i = 0; i < b.size(); i++) begin
         int g;
         g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
         for (int k = 0; k < g; k++) begin
            start = i == start_at && k == 0;
            @(negedge clk);
         end
         start = 1'b0;
         checks++;
         if (byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready byte=%0d got=%b exp=1", i, byte_ready);
         end
         byte_valid = 1'b1;
         byte_in    = b[i];
         byte_last  = last && i == b.size() - 1;
         @(negedge clk);
         byte_valid = 1'b0;
         byte_last  = 1'b0;
         byte_in    = 8'($urandom);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({wr_en, byte_ready, busy, done, error, wr_addr, wr_data, word_count, checksum} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b%b%b%b%b %h %h %h %h exp=0", wr_en, byte_ready, busy,
                  done, error, wr_addr, wr_data, word_count, checksum);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready got=%b/%b exp=0/0", byte_ready, busy);
      end
   endtask

   task automatic test_single_word();
      logic [7:0] b[$];
      bit err; int nw; logic [31:0] cks;
      b = '{8'h20, 8'h08, 8'h00, 8'h05};
      model(b, 1'b1, err, nw, cks);
      begin_load();
      checks++;
      if (byte_ready !== 1'b1 || busy !== 1'b1 || word_count !== 32'd0) begin
         failures++;
         $display("FAIL start_load got=%b/%b/%0d exp=1/1/0", byte_ready, busy, word_count);
      end
      drive(b, 1'b1, 0, -1);
      checks++;
      if ({wr_en, done, busy, byte_ready} !== 4'b1100 || word_count !== 32'd1 || wr_data !== 32'h20080005) begin
         failures++;
         $display("FAIL single_word got=%b%b%b%b cnt=%0d data=%h exp=1100 cnt=1 data=20080005",
                  wr_en, done, busy, byte_ready, word_count, wr_data);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || wr_data !== 32'h20080005 || wr_addr !== 32'd0 || checksum !== cks) begin
         failures++;
         $display("FAIL single_hold got=%b %h@%0d cks=%h exp=0 20080005@0 cks=%h", wr_en, wr_data, wr_addr, checksum, cks);
      end
   endtask

   task automatic test_streaming(input int gap, input int start_at);
      logic [7:0] b[$];
      bit err; int nw; logic [31:0] cks;
      for (int i = 0; i < 12; i++) b.push_back(8'(i));
      model(b, 1'b1, err, nw, cks);
      wr_cyc.delete();
      begin_load();
      drive(b, 1'b1, gap, start_at);
      repeat (2) @(negedge clk);
      checks++;
      if (exp_data.size() != 0 || wr_cyc.size() != 3 || word_count !== 32'(nw) || done !== 1'b1) begin
         failures++;
         $display("FAIL stream gap=%0d left=%0d writes=%0d cnt=%0d done=%b exp=0/3/3/1",
                  gap, exp_data.size(), wr_cyc.size(), word_count, done);
      end
      checks++;
      if (wr_cyc.size() == 3 && (wr_cyc[1] - wr_cyc[0] != 4 * (gap + 1) || wr_cyc[2] - wr_cyc[1] != 4 * (gap + 1))) begin
         failures++;
         $display("FAIL stream_spacing got=%0d,%0d exp=%0d", wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1], 4 * (gap + 1));
      end
      checks++;
      if (checksum !== cks) begin
         failures++;
         $display("FAIL stream_checksum got=%h exp=%h", checksum, cks);
      end
   endtask

   task automatic test_partial_tail();
      logic [7:0] b[$];
      bit err; int nw; logic [31:0] cks;
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      model(b, 1'b1, err, nw, cks);
      begin_load();
      drive(b, 1'b1, 0, -1);
      checks++;
      if (wr_en !== 1'b1 || done !== 1'b1 || wr_data !== 32'h11220000 || wr_addr !== 32'd1) begin
         failures++;
         $display("FAIL tail got=%b%b %h@%0d exp=11 11220000@1", wr_en, done, wr_data, wr_addr);
      end
      @(negedge clk);
      checks++;
      if (exp_data.size() != 0 || word_count !== 32'd2 || checksum !== cks) begin
         failures++;
         $display("FAIL tail_end left=%0d cnt=%0d cks=%h exp=0/2/%h", exp_data.size(), word_count, checksum, cks);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b[$];
      bit err; int nw; logic [31:0] cks;
      for (int i = 0; i < 4 * DEPTH + 1; i++) b.push_back(8'($urandom));
      model(b, 1'b0, err, nw, cks);
      begin_load();
      drive(b, 1'b0, 0, -1);
      checks++;
      if ({error, byte_ready, busy, done} !== 4'b1000 || word_count !== 32'(DEPTH)) begin
         failures++;
         $display("FAIL overflow got=%b%b%b%b cnt=%0d exp=1000 cnt=%0d", error, byte_ready, busy, done, word_count, DEPTH);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (exp_data.size() != 0 || error !== 1'b1 || checksum !== cks) begin
         failures++;
         $display("FAIL overflow_hold left=%0d err=%b cks=%h exp=0/1/%h", exp_data.size(), error, checksum, cks);
      end
      begin_load();
      checks++;
      if ({error, byte_ready, busy} !== 3'b011 || word_count !== 32'd0 || checksum !== 32'd0) begin
         failures++;
         $display("FAIL overflow_recover got=%b%b%b cnt=%0d cks=%h exp=011 cnt=0 cks=0", error, byte_ready, busy, word_count, checksum);
      end
      apply_reset();
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] b[$];
      bit err; int nw; logic [31:0] cks;
      begin_load();
      b = '{8'hAA, 8'hBB};
      drive(b, 1'b0, 0, -1);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, byte_ready, busy, done, error, wr_addr, wr_data, word_count, checksum} !== '0) begin
         failures++;
         $display("FAIL async_reset got=%b%b%b%b%b cnt=%0d exp=0", wr_en, byte_ready, busy, done, error, word_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      b = '{8'h01, 8'h02, 8'h03, 8'h04};
      model(b, 1'b0, err, nw, cks);
      begin_load();
      drive(b, 1'b0, 0, -1);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 32'h01020304 || wr_addr !== 32'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL after_reset got=%b %h@%0d busy=%b exp=1 01020304@0 busy=1", wr_en, wr_data, wr_addr, busy);
      end
      @(negedge clk);
      apply_reset();
   endtask

   task automatic test_random();
      for (int t = 0; t < 10; t++) begin
         logic [7:0] b[$];
         bit last, err; int nw; logic [31:0] cks;
         int n;
         n = int'($urandom_range(1, 4 * DEPTH + 1));
         last = 1'($urandom);
         for (int i = 0; i < n; i++) b.push_back(8'($urandom));
         model(b, last, err, nw, cks);
         begin_load();
         drive(b, last, -1, int'($urandom_range(0, 20)));
         repeat (2) @(negedge clk);
         checks++;
         if (exp_data.size() != 0 || word_count !== 32'(nw) || error !== err || done !== (last && !err) || checksum !== cks) begin
            failures++;
            $display("FAIL random t=%0d n=%0d last=%b left=%0d cnt=%0d/%0d err=%b/%b done=%b cks=%h/%h",
                     t, n, last, exp_data.size(), word_count, nw, error, err, done, checksum, cks);
         end
         exp_data.delete();
         exp_addr.delete();
         if (!last && !err) apply_reset();
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_streaming(0, -1);
      test_partial_tail();
      test_overflow();
      test_reset_mid_load();
      test_streaming(2, 5);
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
